serv_wb_mem: RTL and testbench
==============================

# serv_wb_mem

Wishbone responder that sits at the far end of the SERV core's instruction and data buses. It serves the core's ibus (read-only) and dbus (read/write, byte-selected) from a single shared word memory through a fixed-priority arbiter. It also hosts a memory-mapped 32-bit machine timer that drives the core's timer interrupt input. It is the slave counterpart that completes the core into a minimal runnable system.

## Interface
- DEPTH, 8192: memory size in bytes; power of two, ≥ 8; word count = DEPTH/4.
- clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_ibus_adr  in  32  instruction fetch address.
- i_ibus_cyc  in  1  fetch request; held until ack.
- o_ibus_rdt  out  32  fetch data; valid while o_ibus_ack=1.
- o_ibus_ack  out  1  single-cycle fetch acknowledge.
- i_dbus_adr  in  32  data address.
- i_dbus_dat  in  32  write data.
- i_dbus_sel  in  4  byte enables; bit n covers bits [8n+7:8n].
- i_dbus_we  in  1  1 = write, 0 = read.
- i_dbus_cyc  in  1  data request; held until ack.
- o_dbus_rdt  out  32  read data; valid while o_dbus_ack=1.
- o_dbus_ack  out  1  single-cycle data acknowledge.
- o_timer_irq  out  1  registered (mtime ≥ mtimecmp), unsigned compare.

## Operation
- FSM states:
  - IDLE, IACK, DACK.
  - IDLE & i_dbus_cyc → DACK.
  - IDLE & !i_dbus_cyc & i_ibus_cyc → IACK.
  - IACK → IDLE; DACK → IDLE, unconditionally.
- Priority: dbus wins when both cyc are high in IDLE. The ibus request stays pending and is accepted on the next IDLE cycle.
- Accept edge (IDLE → xACK):
  - The addressed word is read into a single shared read register.
  - A dbus write commits the selected bytes at this edge.
  - On a write, the read register captures the pre-write word; its contents are don't-care for writes.
  - i_dbus_sel is ignored for reads; the full word is returned.
- Ack outputs: o_ibus_ack = (state==IACK); o_dbus_ack = (state==DACK). The two are never high together.
- o_ibus_rdt and o_dbus_rdt are both driven from the read register.
- Address decode:
  - i_*_adr[31]=0 → memory; word index = adr[log2(DEPTH)-1:2]. Upper bits are ignored, so the address space aliases. adr[1:0] is ignored.
  - i_*_adr[31]=1 → timer; word offset adr[3:2]: 0 = mtime, 2 = mtimecmp, 1 and 3 read 0 and ignore writes.
  - An ibus fetch from the timer region returns the timer register value.
- Timer:
  - mtime increments by 1 every cycle and wraps 0xFFFFFFFF → 0.
  - A dbus write to mtime or mtimecmp updates the selected bytes at the accept edge. For mtime, the written value replaces that cycle's increment.
  - o_timer_irq <= (mtime ≥ mtimecmp), evaluated each cycle.
  - To clear the interrupt, software writes mtimecmp > mtime.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values (async on i_rst_n=0):
  - state=IDLE; o_ibus_ack=0; o_dbus_ack=0; read register=0 (both rdt outputs = 0).
  - mtime=0; mtimecmp=0xFFFFFFFF; o_timer_irq=0.
- Latency:
  - cyc sampled high in IDLE at edge N → ack high for exactly cycle N..N+1, then low.
  - Minimum request-to-ack is 1 cycle. Back-to-back requests from the same port ack at best every 2 cycles.
- Handshake:
  - The requester must drop cyc at the edge where ack is high.
  - cyc still high in IDLE after an ack is treated as a new request.
- Simultaneous requests: dbus ack in cycle 1, ibus ack in cycle 3.
- Reset mid-operation:
  - Ack drops immediately.
  - A write already committed at an accept edge persists.
  - A request not yet accepted is discarded.
- Timer compare is registered:
  - o_timer_irq rises 1 cycle after mtime reaches mtimecmp.
  - o_timer_irq falls 1 cycle after a mtimecmp write makes the compare false.

## Test plan
- Reset, then hold i_ibus_cyc=1 with adr=0x00000008 on preloaded word 0xDEADBEEF → o_ibus_ack high exactly 1 cycle later with o_ibus_rdt=0xDEADBEEF; no o_dbus_ack.
- dbus write 0x11223344 sel=4'b0101 to 0x10 over existing 0xAABBCCDD, then dbus read 0x10 → 0xAA22CC44; each transaction acks once, 1 cycle after request.
- Assert ibus cyc (adr 0x0) and dbus read cyc (adr 0x4) in the same cycle → o_dbus_ack in cycle 1, o_ibus_ack in cycle 3, never both high together.
- Write mtimecmp (0x80000008) = mtime+20 → o_timer_irq rises 1 cycle after mtime equals that value. Then write mtimecmp=0xFFFFFFFF → irq falls 1 cycle later.
- Alias and unmapped: with DEPTH=8192, write to 0x2010 → read back at 0x0010. Read 0x80000004 → 0.
- Assert i_rst_n=0 while in DACK → ack drops asynchronously and mtime=0. After release, the next request acks normally.

Source files
------------

// File: rtl/serv_wb_mem_if.sv
// serv_wb_mem_if: SERV ibus/dbus Wishbone signals between core (master) and memory (slave)
interface serv_wb_mem_if;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  modport master (
    output ibus_adr, ibus_cyc, dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    input  ibus_rdt, ibus_ack, dbus_rdt, dbus_ack
  );
  modport slave (
    input  ibus_adr, ibus_cyc, dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    output ibus_rdt, ibus_ack, dbus_rdt, dbus_ack
  );
endinterface

// File: rtl/serv_wb_mem.sv
// serv_wb_mem: shared word memory for SERV ibus/dbus (dbus-priority arbiter) plus machine timer
module serv_wb_mem #(
  parameter int DEPTH = 8192
) (
  input  logic          clk,
  input  logic          i_rst_n,
  serv_wb_mem_if.slave  bus,
  output logic          o_timer_irq
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, IACK, DACK} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH/4];
  logic [31:0] rd_q, rd_d, mtime_q, mtime_d, cmp_q, cmp_d, mask, tmr_rd;
  logic        irq_q, irq_d, dacc, iacc, wr, mem_we, is_tmr;
  logic [1:0]  off;
  logic [AW-3:0] widx;
  logic        unused_adr;
  assign unused_adr = &{1'b0, bus.ibus_adr[30:AW], bus.ibus_adr[1:0],
                        bus.dbus_adr[30:AW], bus.dbus_adr[1:0]};
  always_comb begin
    dacc    = (state_q == IDLE) && bus.dbus_cyc;
    iacc    = (state_q == IDLE) && !bus.dbus_cyc && bus.ibus_cyc;
    is_tmr  = dacc ? bus.dbus_adr[31] : bus.ibus_adr[31];
    off     = dacc ? bus.dbus_adr[3:2] : bus.ibus_adr[3:2];
    widx    = dacc ? bus.dbus_adr[AW-1:2] : bus.ibus_adr[AW-1:2];
    mask    = {{8{bus.dbus_sel[3]}}, {8{bus.dbus_sel[2]}}, {8{bus.dbus_sel[1]}}, {8{bus.dbus_sel[0]}}};
    wr      = dacc && bus.dbus_we;
    mem_we  = wr && !is_tmr && i_rst_n;
    tmr_rd  = (off == 2'd0) ? mtime_q : (off == 2'd2) ? cmp_q : '0;
    state_d = dacc ? DACK : iacc ? IACK : IDLE;
    // the read register captures the old word even on writes; memory commits at the same edge
    rd_d    = (dacc || iacc) ? (is_tmr ? tmr_rd : mem[widx]) : rd_q;
    mtime_d = (wr && is_tmr && off == 2'd0) ? ((mtime_q & ~mask) | (bus.dbus_dat & mask)) : mtime_q + 32'd1;
    cmp_d   = (wr && is_tmr && off == 2'd2) ? ((cmp_q & ~mask) | (bus.dbus_dat & mask)) : cmp_q;
    irq_d   = mtime_q >= cmp_q;
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && bus.dbus_sel[b]) mem[widx][8*b +: 8] <= bus.dbus_dat[8*b +: 8];
  end
  assign bus.ibus_ack = (state_q == IACK);
  assign bus.dbus_ack = (state_q == DACK);
  assign bus.ibus_rdt = rd_q;
  assign bus.dbus_rdt = rd_q;
  assign o_timer_irq  = irq_q;
endmodule

// File: tb/tb_serv_wb_mem.sv
// tb_serv_wb_mem: directed stimulus against a transaction-level model of memory, arbiter and timer
module tb_serv_wb_mem;
  localparam int DEPTH = 8192;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
  int total = 0;
  int bad = 0;
  serv_wb_mem_if bus();
  serv_wb_mem #(.DEPTH(DEPTH)) dut (.clk(clk), .i_rst_n(rst_n), .bus(bus), .o_timer_irq(irq));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: memory as sparse word map, mtime as base value plus elapsed cycles
  logic [31:0] mm [int];
  bit          e_iack = 0, e_dack = 0, e_known = 1, e_irq = 0;
  logic [31:0] e_rdt = '0, cmp_m = '1, mt_base = '0;
  longint      n = 0, mt_n0 = 0;
  logic [31:0] m_a, m_cur, m_mask, m_old;
  bit          m_acd, m_aci;
  int          m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_iack = 0; e_dack = 0; e_rdt = '0; e_known = 1; e_irq = 0;
      n = 0; mt_base = '0; mt_n0 = 0; cmp_m = '1;
    end else begin
      m_cur = mt_base + 32'(n - mt_n0);
      m_acd = !e_iack && !e_dack && bus.dbus_cyc;
      m_aci = !e_iack && !e_dack && !bus.dbus_cyc && bus.ibus_cyc;
      e_irq = m_cur >= cmp_m;
      if (m_acd || m_aci) begin
        m_a = m_acd ? bus.dbus_adr : bus.ibus_adr;
        m_idx = int'(m_a[12:2]);
        m_mask = {{8{bus.dbus_sel[3]}}, {8{bus.dbus_sel[2]}}, {8{bus.dbus_sel[1]}}, {8{bus.dbus_sel[0]}}};
        if (m_a[31]) begin
          e_known = 1;
          e_rdt = (m_a[3:2] == 2'd0) ? m_cur : (m_a[3:2] == 2'd2) ? cmp_m : 32'd0;
        end else begin
          e_known = mm.exists(m_idx);
          e_rdt = e_known ? mm[m_idx] : 32'd0;
        end
        if (m_acd && bus.dbus_we) begin
          if (m_a[31]) begin
            if (m_a[3:2] == 2'd0) begin
              mt_base = (m_cur & ~m_mask) | (bus.dbus_dat & m_mask);
              mt_n0 = n + 1;
            end else if (m_a[3:2] == 2'd2) cmp_m = (cmp_m & ~m_mask) | (bus.dbus_dat & m_mask);
          end else if (mm.exists(m_idx) || bus.dbus_sel == 4'hF) begin
            m_old = mm.exists(m_idx) ? mm[m_idx] : 32'd0;
            mm[m_idx] = (m_old & ~m_mask) | (bus.dbus_dat & m_mask);
          end
        end
      end
      e_iack = m_aci;
      e_dack = m_acd;
      n++;
    end
  end

  always @(negedge clk) begin
    chk("ibus_ack", {31'd0, bus.ibus_ack}, {31'd0, e_iack});
    chk("dbus_ack", {31'd0, bus.dbus_ack}, {31'd0, e_dack});
    chk("ack_excl", {31'd0, bus.ibus_ack & bus.dbus_ack}, 32'd0);
    chk("timer_irq", {31'd0, irq}, {31'd0, e_irq});
    if (e_iack && e_known) chk("ibus_rdt", bus.ibus_rdt, e_rdt);
    if (e_dack && e_known) chk("dbus_rdt", bus.dbus_rdt, e_rdt);
  end

  task automatic dxfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [31:0] r);
    int lat = -1;
    r = '0;
    @(negedge clk);
    bus.dbus_adr = a; bus.dbus_dat = d; bus.dbus_sel = s; bus.dbus_we = w; bus.dbus_cyc = 1'b1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.dbus_ack) begin lat = i; r = bus.dbus_rdt; end
    end
    bus.dbus_cyc = 1'b0;
    chk("dbus_latency", lat, 1);
  endtask

  task automatic dwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    dxfer(a, d, s, 1'b1, r);
  endtask

  task automatic drd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    dxfer(a, 32'd0, 4'h0, 1'b0, r);
    chk(nm, r, exp);
  endtask

  task automatic ifetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
    int lat = -1;
    bit dseen = 0;
    logic [31:0] r = '0;
    @(negedge clk);
    bus.ibus_adr = a; bus.ibus_cyc = 1'b1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.dbus_ack) dseen = 1;
      if (bus.ibus_ack) begin lat = i; r = bus.ibus_rdt; end
    end
    bus.ibus_cyc = 1'b0;
    chk("ibus_latency", lat, 1);
    chk("ibus_no_dack", {31'd0, dseen}, 32'd0);
    chk(nm, r, exp);
  endtask

  initial begin
    int dcy, icy;
    bit both;
    logic [31:0] drv, irv;
    bus.ibus_adr = '0; bus.ibus_cyc = 0; bus.dbus_adr = '0; bus.dbus_dat = '0;
    bus.dbus_sel = '0; bus.dbus_we = 0; bus.dbus_cyc = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_iack", {31'd0, bus.ibus_ack}, 32'd0);
    chk("rst_dack", {31'd0, bus.dbus_ack}, 32'd0);
    chk("rst_irdt", bus.ibus_rdt, 32'd0);
    chk("rst_drdt", bus.dbus_rdt, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    // preload, then reset again: memory must survive
    dwr(32'h8, 32'hDEADBEEF, 4'hF);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    ifetch("fetch_preload", 32'h8, 32'hDEADBEEF);
    dwr(32'h10, 32'hAABBCCDD, 4'hF);
    dwr(32'h10, 32'h11223344, 4'b0101);
    drd("byte_merge", 32'h10, 32'hAA22CC44);
    // simultaneous requests
    dwr(32'h0, 32'h01020304, 4'hF);
    dwr(32'h4, 32'h0A0B0C0D, 4'hF);
    @(negedge clk);
    bus.ibus_adr = 32'h0; bus.ibus_cyc = 1;
    bus.dbus_adr = 32'h4; bus.dbus_we = 0; bus.dbus_cyc = 1;
    dcy = -1; icy = -1; both = 0; drv = '0; irv = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.ibus_ack && bus.dbus_ack) both = 1;
      if (bus.dbus_ack) begin bus.dbus_cyc = 0; dcy = c; drv = bus.dbus_rdt; end
      if (bus.ibus_ack) begin bus.ibus_cyc = 0; icy = c; irv = bus.ibus_rdt; end
    end
    chk("arb_dcycle", dcy, 1);
    chk("arb_icycle", icy, 3);
    chk("arb_both", {31'd0, both}, 32'd0);
    chk("arb_drdt", drv, 32'h0A0B0C0D);
    chk("arb_irdt", irv, 32'h01020304);
    // aliasing and unmapped timer words
    dwr(32'h2010, 32'h5A5A1234, 4'hF);
    drd("alias_rd", 32'h0010, 32'h5A5A1234);
    drd("unmapped_4", 32'h80000004, 32'h0);
    dwr(32'h8000000C, 32'h12345678, 4'hF);
    drd("unmapped_c", 32'h8000000C, 32'h0);
    ifetch("fetch_cmp", 32'h80000008, 32'hFFFFFFFF);
    // timer compare: mtime=100, cmp=140 lands irq after the 41st edge from the mtime write
    dwr(32'h80000000, 32'd100, 4'hF);
    dwr(32'h80000008, 32'd140, 4'hF);
    repeat (38) @(negedge clk);
    chk("irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    dwr(32'h80000008, 32'hFFFFFFFF, 4'hF);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    dwr(32'h80000000, 32'hFFFFFFFF, 4'hF);
    drd("mtime_wrap", 32'h80000000, 32'h0);
    // reset while in DACK
    @(negedge clk);
    bus.dbus_adr = 32'h10; bus.dbus_we = 0; bus.dbus_cyc = 1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.dbus_cyc = 0;
    #1;
    chk("mid_rst_dack", {31'd0, bus.dbus_ack}, 32'd0);
    chk("mid_rst_rdt", bus.dbus_rdt, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    drd("mtime_after_rst", 32'h80000000, 32'd1);
    ifetch("fetch_after_rst", 32'h8, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
